// File: rtl/ifft4_serial.sv
// rtl/ifft4_serial.sv - serial 4-point inverse FFT, one time-multiplexed radix-2 butterfly.
// Optional IFFT4_ROUND_EN: round half up on every butterfly instead of floor.
module ifft4_serial #(
   parameter int BIT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in_re,
   input  logic [BIT_WIDTH-1:0] in_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] out_re,
   output logic [BIT_WIDTH-1:0] out_im,
   output logic [1:0]           out_idx,
   output logic                 out_last,
   output logic                 busy
);
   localparam int W = BIT_WIDTH;

   localparam logic [2:0] LOAD = 3'd0;
   localparam logic [2:0] S1A  = 3'd1;
   localparam logic [2:0] S1B  = 3'd2;
   localparam logic [2:0] S2A  = 3'd3;
   localparam logic [2:0] S2B  = 3'd4;
   localparam logic [2:0] OUT  = 3'd5;

   logic [2:0]   state;
   logic [1:0]   load_cnt;
   logic [1:0]   out_cnt;
   logic [1:0]   out_nxt;
   logic [W-1:0] mem_re [4];
   logic [W-1:0] mem_im [4];

   logic [1:0]        ia, ib;
   logic              rot;
   logic signed [W:0] ar, ai, br, bi;
   logic signed [W:0] sum_re, sum_im, dif_re, dif_im;

   function automatic logic [W-1:0] halve(input logic signed [W:0] s);
`ifdef IFFT4_ROUND_EN
      logic signed [W+1:0] t;
      t = {s[W], s} + (W+2)'(1);
      return t[W:1];
`else
      return s[W:1];
`endif
   endfunction

   // Butterfly operand selection; S2B applies the +j twiddle to the lower operand.
   always_comb begin
      ia  = 2'd0;
      ib  = 2'd1;
      rot = 1'b0;
      case (state)
         S1B:     begin ia = 2'd2; ib = 2'd3; end
         S2A:     begin ia = 2'd0; ib = 2'd2; end
         S2B:     begin ia = 2'd1; ib = 2'd3; rot = 1'b1; end
         default: begin ia = 2'd0; ib = 2'd1; end
      endcase
      ar = {mem_re[ia][W-1], mem_re[ia]};
      ai = {mem_im[ia][W-1], mem_im[ia]};
      if (rot) begin
         br = -{mem_im[ib][W-1], mem_im[ib]};
         bi = {mem_re[ib][W-1], mem_re[ib]};
      end else begin
         br = {mem_re[ib][W-1], mem_re[ib]};
         bi = {mem_im[ib][W-1], mem_im[ib]};
      end
      sum_re = ar + br;
      sum_im = ai + bi;
      dif_re = ar - br;
      dif_im = ai - bi;
   end

   assign out_nxt  = out_cnt + 2'd1;
   assign out_idx  = out_cnt;
   assign in_ready = (state == LOAD);
   assign busy     = (state != LOAD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         load_cnt  <= 2'd0;
         out_cnt   <= 2'd0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid) begin
                  mem_re[{load_cnt[0], load_cnt[1]}] <= in_re;
                  mem_im[{load_cnt[0], load_cnt[1]}] <= in_im;
                  load_cnt <= load_cnt + 2'd1;
                  if (load_cnt == 2'd3) state <= S1A;
               end
            end
            S1A, S1B, S2A, S2B: begin
               mem_re[ia] <= halve(sum_re);
               mem_im[ia] <= halve(sum_im);
               mem_re[ib] <= halve(dif_re);
               mem_im[ib] <= halve(dif_im);
               state      <= (state == S2B) ? OUT : state + 3'd1;
            end
            OUT: begin
               // First OUT cycle registers x[0]; later cycles step on each handshake.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_cnt   <= 2'd0;
                  out_re    <= mem_re[0];
                  out_im    <= mem_im[0];
                  out_last  <= 1'b0;
               end else if (out_ready) begin
                  if (out_cnt == 2'd3) begin
                     state     <= LOAD;
                     out_valid <= 1'b0;
                     out_cnt   <= 2'd0;
                     out_re    <= '0;
                     out_im    <= '0;
                     out_last  <= 1'b0;
                  end else begin
                     out_cnt  <= out_nxt;
                     out_re   <= mem_re[out_nxt];
                     out_im   <= mem_im[out_nxt];
                     out_last <= (out_nxt == 2'd3);
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_ifft4_serial.sv
// tb/tb_ifft4_serial.sv - directed self-checking bench for ifft4_serial.
module tb_ifft4_serial;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_re, in_im;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_re, out_im;
   logic [1:0] out_idx;
   logic       out_last;
   logic       busy;

   int errors = 0;
   int checks = 0;

   ifft4_serial #(.BIT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic send_bins(input logic [31:0] xre, input logic [31:0] xim, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_re    = xre[8*i +: 8];
         in_im    = xim[8*i +: 8];
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_re    = 8'h5a;
      in_im    = 8'ha5;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, out_last, out_idx, out_re, out_im} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0}) begin
         errors++;
         $display("FAIL reset: rdy/vld/busy/last/idx/re/im got %b%b%b%b %0d %0d %0d", in_ready, out_valid, busy, out_last, out_idx, out_re, out_im);
      end
   endtask

   task automatic test_frame(input string name, input logic [31:0] xre, input logic [31:0] xim,
                             input logic [31:0] ere, input logic [31:0] eim);
      int lat;
      out_ready = 1'b1;
      send_bins(xre, xim, 4);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL %s latency: got %0d edges, expected 5", name, lat);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({out_valid, out_idx, out_last, out_re, out_im} !== {1'b1, 2'(i), (i == 3), ere[8*i +: 8], eim[8*i +: 8]}) begin
            errors++;
            $display("FAIL %s sample %0d: vld=%b idx=%0d last=%b re=%0d im=%0d, expected re=%0d im=%0d",
                     name, i, out_valid, out_idx, out_last, $signed(out_re), $signed(out_im),
                     $signed(ere[8*i +: 8]), $signed(eim[8*i +: 8]));
         end
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         errors++;
         $display("FAIL %s end of frame: vld/in_ready/busy got %b%b%b, expected 010", name, out_valid, in_ready, busy);
      end
   endtask

   task automatic test_backpressure();
      int t;
      out_ready = 1'b0;
      send_bins(32'h00000040, 32'h0, 4);
      t = 0;
      while (!out_valid && t < 20) begin
         @(posedge clk); @(negedge clk); t++;
      end
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({out_valid, out_re, out_idx, in_ready} !== {1'b1, 8'd16, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL backpressure hold %0d: vld=%b re=%0d idx=%0d in_ready=%b, expected 1 16 0 0", c, out_valid, out_re, out_idx, in_ready);
         end
         @(posedge clk); @(negedge clk);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({out_valid, out_idx, out_last, out_re, out_im} !== {1'b1, 2'(i), (i == 3), 8'd16, 8'd0}) begin
            errors++;
            $display("FAIL backpressure sample %0d: vld=%b idx=%0d last=%b re=%0d im=%0d, expected 16 0", i, out_valid, out_idx, out_last, out_re, out_im);
         end
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL backpressure release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_frame();
      send_bins(32'h00007f64, 32'h000080c0, 2);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL mid-frame reset: in_ready/vld/busy got %b%b%b, expected 100", in_ready, out_valid, busy);
      end
      test_frame("post_reset_dc", 32'h00000040, 32'h0, 32'h10101010, 32'h0);
   endtask

   initial begin
      test_reset();
      test_frame("dc", 32'h00000040, 32'h0, 32'h10101010, 32'h0);
      test_frame("bin1", 32'h00004000, 32'h0, 32'h00f00010, 32'hf0001000);
      test_frame("bin3_imag", 32'h0, 32'h40000000, 32'hf0001000, 32'h00f00010);
      test_frame("full_scale_neg", 32'h80808080, 32'h80808080, 32'h00000080, 32'h00000080);
`ifdef IFFT4_ROUND_EN
      test_frame("round_pos", 32'h00000001, 32'h0, 32'h01010101, 32'h0);
      test_frame("round_neg", 32'h000000ff, 32'h0, 32'h00000000, 32'h0);
`else
      test_frame("round_pos", 32'h00000001, 32'h0, 32'h00000000, 32'h0);
      test_frame("round_neg", 32'h000000ff, 32'h0, 32'hffffffff, 32'h0);
`endif
      test_backpressure();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
